// File: rtl/lt24_panel_rx.sv
// rtl/lt24_panel_rx.sv - LT24 panel-side receiver: command decode, address window, pixel stream, Read-ID
module lt24_panel_rx #(
  parameter int          WIDTH    = 320,
  parameter int          HEIGHT   = 240,
  parameter int          ADDR_W   = 17,
  parameter logic [23:0] PANEL_ID = 24'h009341
) (
  input  logic              mclk,
  input  logic              puc_rst_n,
  input  logic              lt24_cs_n_i,
  input  logic              lt24_rd_n_i,
  input  logic              lt24_wr_n_i,
  input  logic              lt24_rs_i,
  input  logic [15:0]       lt24_d_i,
  input  logic              lt24_reset_n_i,
  input  logic              lt24_on_i,
  output logic [15:0]       lt24_d_o,
  output logic              pix_we_o,
  output logic [ADDR_W-1:0] pix_addr_o,
  output logic [15:0]       pix_data_o,
  output logic              disp_on_o,
  output logic              frame_done_o
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0]     EC_RST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0]     EP_RST  = RW'(HEIGHT - 1);
  localparam logic [15:0]       WIDTH16 = 16'(WIDTH);
  localparam logic [15:0]       HEIGHT16 = 16'(HEIGHT);
  localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_PARAM, S_RAMWR, S_READ} state_t;

  // bus input stage
  logic        cs_n_q, rd_n_q, wr_n_q, rs_q, pin_rst_n_q, on_q;
  logic [15:0] d_q;

  // event pipeline: stage 1 captured on the strobe's rising sample, stage 2 feeds the decoder
  logic        ev1_wr_q, ev1_rd_q, ev1_rs_q, ev2_wr_q, ev2_rd_q, ev2_rs_q;
  logic [15:0] ev1_d_q, ev2_d_q;

  // decoder state
  state_t            state_q, state_d;
  logic [CW-1:0]     sc_q, sc_d, ec_q, ec_d, col_q, col_d;
  logic [RW-1:0]     sp_q, sp_d, ep_q, ep_d, row_q, row_d;
  logic [1:0]        pcnt_q, pcnt_d, idx_q, idx_d;
  logic              is_pa_q, is_pa_d;
  logic [23:0]       pbuf_q, pbuf_d;
  logic              disp_q, disp_d, pix_we_q, pix_we_d, fd_q, fd_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [15:0]       pix_data_q, pix_data_d, d_o_q, d_o_d, id_word;

  logic              wr_ev, rd_ev, soft_rst;
  logic [15:0]       p_start, p_end;
  logic [ADDR_W-1:0] cur_addr;

  // a write wins over a simultaneous read; strobes with chip select high never count
  assign wr_ev    = ~wr_n_q & lt24_wr_n_i & ~cs_n_q;
  assign rd_ev    = ~rd_n_q & lt24_rd_n_i & ~cs_n_q & ~wr_ev;
  assign soft_rst = ~pin_rst_n_q | ~on_q;
  assign p_start  = pbuf_q[23:8];
  assign p_end    = {pbuf_q[7:0], ev2_d_q[7:0]};
  assign cur_addr = ADDR_W'(row_q) * WIDTH_A + ADDR_W'(col_q);

  // input sampling and event pipeline
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      rs_q        <= 1'b0;
      d_q         <= 16'h0;
      pin_rst_n_q <= 1'b1;
      on_q        <= 1'b1;
      ev1_wr_q    <= 1'b0;
      ev1_rd_q    <= 1'b0;
      ev1_rs_q    <= 1'b0;
      ev1_d_q     <= 16'h0;
      ev2_wr_q    <= 1'b0;
      ev2_rd_q    <= 1'b0;
      ev2_rs_q    <= 1'b0;
      ev2_d_q     <= 16'h0;
    end else begin
      cs_n_q      <= lt24_cs_n_i;
      rd_n_q      <= lt24_rd_n_i;
      wr_n_q      <= lt24_wr_n_i;
      rs_q        <= lt24_rs_i;
      d_q         <= lt24_d_i;
      pin_rst_n_q <= lt24_reset_n_i;
      on_q        <= lt24_on_i;
      ev1_wr_q    <= wr_ev;
      ev1_rd_q    <= rd_ev;
      ev1_rs_q    <= rs_q;
      ev1_d_q     <= d_q;
      ev2_wr_q    <= ev1_wr_q;
      ev2_rd_q    <= ev1_rd_q;
      ev2_rs_q    <= ev1_rs_q;
      ev2_d_q     <= ev1_d_q;
    end
  end

  // decoder state register and registered outputs
  always_ff @(posedge mclk) begin
    if (!puc_rst_n) begin
      state_q    <= S_IDLE;
      sc_q       <= '0;
      ec_q       <= EC_RST;
      sp_q       <= '0;
      ep_q       <= EP_RST;
      col_q      <= '0;
      row_q      <= '0;
      pcnt_q     <= 2'd0;
      idx_q      <= 2'd0;
      is_pa_q    <= 1'b0;
      pbuf_q     <= 24'h0;
      disp_q     <= 1'b0;
      pix_we_q   <= 1'b0;
      fd_q       <= 1'b0;
      pix_addr_q <= '0;
      pix_data_q <= 16'h0;
      d_o_q      <= 16'h0;
    end else begin
      state_q    <= state_d;
      sc_q       <= sc_d;
      ec_q       <= ec_d;
      sp_q       <= sp_d;
      ep_q       <= ep_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      is_pa_q    <= is_pa_d;
      pbuf_q     <= pbuf_d;
      disp_q     <= disp_d;
      pix_we_q   <= pix_we_d;
      fd_q       <= fd_d;
      pix_addr_q <= pix_addr_d;
      pix_data_q <= pix_data_d;
      d_o_q      <= d_o_d;
    end
  end

  // command/parameter/pixel/read decode; panel reset pins behave like SWRESET while held
  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    ec_d       = ec_q;
    sp_d       = sp_q;
    ep_d       = ep_q;
    col_d      = col_q;
    row_d      = row_q;
    pcnt_d     = pcnt_q;
    idx_d      = idx_q;
    is_pa_d    = is_pa_q;
    pbuf_d     = pbuf_q;
    disp_d     = disp_q;
    pix_we_d   = 1'b0;
    fd_d       = 1'b0;
    pix_addr_d = pix_addr_q;
    pix_data_d = pix_data_q;
    id_word    = 16'h0;

    if (soft_rst || (ev2_wr_q && !ev2_rs_q && ev2_d_q[7:0] == 8'h01)) begin
      state_d    = S_IDLE;
      sc_d       = '0;
      ec_d       = EC_RST;
      sp_d       = '0;
      ep_d       = EP_RST;
      col_d      = '0;
      row_d      = '0;
      pcnt_d     = 2'd0;
      idx_d      = 2'd0;
      is_pa_d    = 1'b0;
      pbuf_d     = 24'h0;
      disp_d     = 1'b0;
      pix_addr_d = '0;
      pix_data_d = 16'h0;
    end else if (ev2_wr_q && !ev2_rs_q) begin
      state_d = S_IDLE;
      pcnt_d  = 2'd0;
      case (ev2_d_q[7:0])
        8'h28: disp_d = 1'b0;
        8'h29: disp_d = 1'b1;
        8'h2A: begin state_d = S_PARAM; is_pa_d = 1'b0; end
        8'h2B: begin state_d = S_PARAM; is_pa_d = 1'b1; end
        8'h2C: begin state_d = S_RAMWR; col_d = sc_q; row_d = sp_q; end
        8'h3C: state_d = S_RAMWR;
        8'h04: begin state_d = S_READ; idx_d = 2'd0; end
        default: ;
      endcase
    end else if (ev2_wr_q) begin
      case (state_q)
        S_PARAM: begin
          if (pcnt_q == 2'd3) begin
            state_d = S_IDLE;
            pcnt_d  = 2'd0;
            if (!is_pa_q && p_start <= p_end && p_end < WIDTH16) begin
              sc_d = p_start[CW-1:0];
              ec_d = p_end[CW-1:0];
            end
            if (is_pa_q && p_start <= p_end && p_end < HEIGHT16) begin
              sp_d = p_start[RW-1:0];
              ep_d = p_end[RW-1:0];
            end
          end else begin
            pbuf_d = {pbuf_q[15:0], ev2_d_q[7:0]};
            pcnt_d = pcnt_q + 2'd1;
          end
        end
        S_RAMWR: begin
          pix_we_d   = 1'b1;
          pix_addr_d = cur_addr;
          pix_data_d = ev2_d_q;
          fd_d       = (col_q == ec_q) && (row_q == ep_q);
          if (col_q == ec_q) begin
            col_d = sc_q;
            row_d = (row_q == ep_q) ? sp_q : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        default: ;
      endcase
    end else if (ev2_rd_q && state_q == S_READ) begin
      if (idx_q == 2'd3) begin
        state_d = S_IDLE;
        idx_d   = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end

    case (idx_d)
      2'd2:    id_word = {8'h00, PANEL_ID[15:8]};
      2'd3:    id_word = {8'h00, PANEL_ID[7:0]};
      default: id_word = 16'h0;
    endcase
    d_o_d = (state_d == S_READ) ? id_word : 16'h0;
  end

  assign lt24_d_o     = d_o_q;
  assign pix_we_o     = pix_we_q;
  assign pix_addr_o   = pix_addr_q;
  assign pix_data_o   = pix_data_q;
  assign disp_on_o    = disp_q;
  assign frame_done_o = fd_q;

endmodule

// File: tb/tb_lt24_panel_rx.sv
// tb/tb_lt24_panel_rx.sv - randomized self-checking bench for lt24_panel_rx against a window/cursor model
`timescale 1ns/1ps
module tb_lt24_panel_rx;
  localparam int W  = 320;
  localparam int H  = 240;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, rs = 1'b0;
  logic [15:0]   d = 16'h0;
  logic          pin_rst_n = 1'b1, on = 1'b1;
  logic [15:0]   d_o;
  logic          pix_we, disp_on, frame_done;
  logic [AW-1:0] pix_addr;
  logic [15:0]   pix_data;

  int errors = 0;
  int checks = 0;

  // model of the panel: window, cursor, expected pixel writes {frame_done, addr, data}
  int sc, ec, sp, ep, col, row;
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];

  always #5 clk = ~clk;

  lt24_panel_rx #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .PANEL_ID(24'h009341)) dut (
    .mclk(clk), .puc_rst_n(rst_n), .lt24_cs_n_i(cs_n), .lt24_rd_n_i(rd_n),
    .lt24_wr_n_i(wr_n), .lt24_rs_i(rs), .lt24_d_i(d), .lt24_reset_n_i(pin_rst_n),
    .lt24_on_i(on), .lt24_d_o(d_o), .pix_we_o(pix_we), .pix_addr_o(pix_addr),
    .pix_data_o(pix_data), .disp_on_o(disp_on), .frame_done_o(frame_done)
  );

  always @(negedge clk) begin
    if (pix_we) obs_q.push_back({frame_done, pix_addr, pix_data});
  end

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    sc = 0; ec = W - 1; sp = 0; ep = H - 1; col = 0; row = 0;
  endtask

  task automatic bus_wr(input logic r, input logic [15:0] v);
    cs_n = 1'b0; rs = r; d = v; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] op);
    bus_wr(1'b0, {8'h00, op});
    if (op == 8'h2C) begin col = sc; row = sp; end
    if (op == 8'h01) m_reset();
  endtask

  task automatic set_window(input logic pa, input int s, input int e);
    logic [15:0] sv, ev;
    sv = 16'(s);
    ev = 16'(e);
    cmd(pa ? 8'h2B : 8'h2A);
    bus_wr(1'b1, {8'h00, sv[15:8]});
    bus_wr(1'b1, {8'h00, sv[7:0]});
    bus_wr(1'b1, {8'h00, ev[15:8]});
    bus_wr(1'b1, {8'h00, ev[7:0]});
    if (s <= e && e < (pa ? H : W)) begin
      if (pa) begin sp = s; ep = e; end
      else    begin sc = s; ec = e; end
    end
  endtask

  task automatic m_pixel(input logic [15:0] v);
    logic fd;
    fd = (col == ec) && (row == ep);
    exp_q.push_back({fd, 17'(row * W + col), v});
    if (col == ec) begin
      col = sc;
      if (row == ep) row = sp; else row++;
    end else begin
      col++;
    end
  endtask

  task automatic pixel(input logic [15:0] v);
    bus_wr(1'b1, v);
    m_pixel(v);
  endtask

  task automatic drain_check(input string tag);
    int n;
    repeat (6) @(negedge clk);
    check({tag, "_count"}, 34'(obs_q.size()), 34'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic rd_strobe(input string tag, input logic [15:0] exp);
    cs_n = 1'b0; rd_n = 1'b0;
    repeat (2) @(negedge clk);
    check(tag, 34'(d_o), 34'(exp));
    rd_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_d_o", 34'(d_o), 34'h0);
    check("rst_outs", {30'h0, pix_we, disp_on, frame_done, 1'b0}, 34'h0);
    check("rst_addr_data", {1'b0, pix_addr, pix_data}, 34'h0);

    // basic RAMWR from origin
    cmd(8'h2C);
    pixel(16'hF800); pixel(16'h07E0); pixel(16'h001F);
    drain_check("ramwr_basic");

    // display on, then panel reset pin pulse
    cmd(8'h29);
    repeat (3) @(negedge clk);
    check("disp_on", 34'(disp_on), 34'h1);
    pin_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    pin_rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("disp_off_after_pin_rst", 34'(disp_on), 34'h0);
    m_reset();
    cmd(8'h2C);
    pixel(16'h1234);
    drain_check("pin_rst_pixel");

    // invalid CASET (start > end) leaves window unchanged
    set_window(1'b0, 20, 10);
    cmd(8'h2C);
    pixel(16'hABCD);
    drain_check("caset_invalid");

    // truncated CASET aborted by RAMWR
    cmd(8'h2A);
    bus_wr(1'b1, 16'h0000);
    bus_wr(1'b1, 16'h0032);
    cmd(8'h2C);
    pixel(16'h5555);
    pixel(16'h6666);
    drain_check("caset_abort");

    // small window with wrap and frame_done
    set_window(1'b0, 10, 12);
    set_window(1'b1, 5, 6);
    cmd(8'h2C);
    for (int i = 0; i < 7; i++) pixel(16'(16'h0100 + i));
    drain_check("window_wrap");

    // Read-ID
    cmd(8'h04);
    repeat (4) @(negedge clk);
    rd_strobe("rdid0", 16'h0000);
    rd_strobe("rdid1", 16'h0000);
    rd_strobe("rdid2", 16'h0093);
    rd_strobe("rdid3", 16'h0041);
    rd_strobe("rdid4", 16'h0000);

    // pixel pulse latency: 2nd edge after the first edge that samples wr_n high
    cmd(8'h2C);
    cs_n = 1'b0; rs = 1'b1; d = 16'hBEEF; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    check("lat_e0", 34'(pix_we), 34'h0);
    @(negedge clk);
    check("lat_e1", 34'(pix_we), 34'h0);
    @(negedge clk);
    check("lat_e2", 34'(pix_we), 34'h1);
    m_pixel(16'hBEEF);
    drain_check("latency");

    // strobe with chip select high is ignored
    cs_n = 1'b1; rs = 1'b1; d = 16'h7777; wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1;
    @(negedge clk);
    pixel(16'h8888);
    drain_check("cs_high");

    // SWRESET and RAMWRC
    set_window(1'b0, 100, 101);
    cmd(8'h01);
    cmd(8'h2C);
    pixel(16'h0001);
    cmd(8'h3C);
    pixel(16'h0002);
    drain_check("swreset_ramwrc");

    // randomized windows and bursts
    for (int it = 0; it < 25; it++) begin
      int s, e, n;
      s = $urandom_range(0, W - 1);
      e = ($urandom_range(0, 3) == 0) ? s - 1 : s + $urandom_range(0, 4);
      set_window(1'b0, s, e);
      s = $urandom_range(0, H - 1);
      e = ($urandom_range(0, 3) == 0) ? s - 1 : s + $urandom_range(0, 3);
      set_window(1'b1, s, e);
      cmd(8'h2C);
      n = $urandom_range(1, 30);
      for (int k = 0; k < n; k++) pixel(16'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        cmd(8'h3C);
        n = $urandom_range(1, 10);
        for (int k = 0; k < n; k++) pixel(16'($urandom));
      end
      drain_check("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lt24_panel_rx.md
# lt24_panel_rx

Panel-side receiver for the openGFX430 LT24 LCD bus. It is a synthesizable model of the ILI9341-style controller that sits on the far end of `lt24_*` and is used in system simulation and as an on-chip loopback target. It decodes the write strobes that the graphics controller issues as commands and parameters. It maintains the column/page address window, streams pixel writes into a framebuffer port, and answers Read-ID transactions on the data bus.

## Interface
Parameters:
- `WIDTH`, 320, panel columns
- `HEIGHT`, 240, panel rows
- `ADDR_W`, 17, framebuffer address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT
- `PANEL_ID`, 24'h009341, value returned by Read-ID

Ports:
- `mclk`  in  1  system clock; all bus inputs are synchronous to it
- `puc_rst_n`  in  1  synchronous active-low reset
- `lt24_cs_n_i`  in  1  chip select, active low
- `lt24_rd_n_i`  in  1  read strobe, active low
- `lt24_wr_n_i`  in  1  write strobe, active low
- `lt24_rs_i`  in  1  0 = command, 1 = parameter/data
- `lt24_d_i`  in  16  bus data from the controller
- `lt24_reset_n_i`  in  1  panel hardware reset, active low
- `lt24_on_i`  in  1  panel power
- `lt24_d_o`  out  16  read data returned to the controller
- `pix_we_o`  out  1  one-cycle framebuffer write pulse
- `pix_addr_o`  out  ADDR_W  framebuffer address = row*WIDTH + col
- `pix_data_o`  out  16  RGB565 pixel
- `disp_on_o`  out  1  display-on state
- `frame_done_o`  out  1  one-cycle pulse when the last window pixel is written

## Operation
- Input stage: all bus inputs are registered once in `_q` registers.
- Write event: fires when `wr_n_q`=0, `lt24_wr_n_i`=1 and `cs_n_q`=0. The event takes `rs_q` and `d_q`.
- Read event: same rule using `rd_n`.
- Strobes with `cs_n` high are ignored.
- A write event with rs=0 is a command. The opcode is `d[7:0]`. A command always aborts any partial parameter collection.
- 0x01 SWRESET: restore reset state. `disp_on_o` is cleared.
- 0x28 / 0x29: clear / set `disp_on_o`.
- 0x2A CASET, 0x2B PASET: go to PARAM and collect 4 bytes from `d[7:0]`, in order start-hi, start-lo, end-hi, end-lo.
  - On the 4th byte, commit start/end only if start ≤ end and end < WIDTH (CASET) or end < HEIGHT (PASET). Otherwise discard.
  - Return to IDLE after the 4th byte. Extra parameter writes in IDLE are ignored.
- 0x2C RAMWR: set the cursor to (SC, SP) and enter RAMWR.
- 0x3C RAMWRC: enter RAMWR without moving the cursor.
- RAMWR, each rs=1 write:
  - Pulse `pix_we_o` with the current address and the full 16-bit data.
  - Advance the cursor: if col = EC then col ← SC and the row advances, else col+1.
  - Row advance: if row = EP then row ← SP, else row+1.
  - Writing (EC, EP) also pulses `frame_done_o` and wraps the cursor to (SC, SP).
- 0x04 Read-ID: enter READ and set the index to 0.
  - `lt24_d_o` shows, by index: 0x0000 (dummy), 0x0000, `PANEL_ID[15:8]`, `PANEL_ID[7:0]`. Bytes sit zero-extended on `d[7:0]`.
  - Each read event increments the index. After index 3 is consumed, return to IDLE.
  - In all other states `lt24_d_o` = 0.
- Unknown opcodes: go to IDLE and are otherwise ignored.
- States: IDLE, PARAM, RAMWR, READ.
- `lt24_reset_n_i` low or `lt24_on_i` low: same effect as SWRESET while asserted.
- Reset state:
  - Window SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1; cursor (0,0); state IDLE.
  - All outputs 0: `lt24_d_o`, `pix_we_o`, `pix_addr_o`, `pix_data_o`, `disp_on_o`, `frame_done_o`.

## Timing
- Latency: `pix_we_o`, `frame_done_o`, the committed window, and state all update on the 2nd `mclk` edge after the edge that first samples `lt24_wr_n_i`=1.
- A write strobe needs ≥1 cycle low and ≥1 cycle high. Back-to-back writes at that rate are sustained, one pixel per 2 cycles.
- `lt24_d_o` is registered. It changes 2 cycles after the read event and is stable for the whole next `rd_n` low phase.
- A simultaneous write event and read event is a protocol error. The write takes priority and the read is dropped.
- `puc_rst_n` low mid-stream: on the next edge, no further `pix_we_o` pulses and all state returns to reset.
- `pix_addr_o` and `pix_data_o` hold their last value between pulses.

## Test plan
- Reset, then cmd 0x2C and 3 data writes 0xF800, 0x07E0, 0x001F -> `pix_we_o` pulses at addresses 0, 1, 2 with matching data.
- CASET 0,10,0,12; PASET 0,5,0,6; RAMWR; 6 pixels -> addresses 1610, 1611, 1612, 1930, 1931, 1932; `frame_done_o` on the 6th. A 7th pixel writes address 1610.
- CASET 0,20,0,10 (start > end), then RAMWR and 1 pixel -> the window is unchanged and the pixel lands at address 0.
- CASET with 2 params, then cmd 0x2C -> parameters are discarded and the first pixel lands at SC/SP of the old window.
- Cmd 0x04, then 4 read strobes -> `lt24_d_o` = 0x0000, 0x0000, 0x0093, 0x0041; a 5th read returns 0x0000.
- Cmd 0x29 then `lt24_reset_n_i` pulsed low 3 cycles -> `disp_on_o` 1 then 0; the next RAMWR pixel goes to address 0.
